wash_cycle_controller: RTL and testbench
========================================

Name: wash_cycle_controller

Overview:
- Washing-machine sequencing FSM that consumes the toggling slow clock from the clock divider.
- Samples that clock in the fast `clk` domain and converts its rising edges into one-cycle `tick` pulses. Each `tick` is one second of machine time.
- Steps through fill, wash, rinse and spin phases, each timed in ticks, and drives the valve, motor and door-lock outputs.
- Owns the cancel, pause and fill-timeout fault policy.

Parameters:
- FILL_T, 8, max ticks allowed in FILL before FAULT.
- WASH_T, 5, WASH duration in ticks.
- RINSE_T, 4, RINSE duration in ticks.
- SPIN_T, 3, SPIN duration in ticks.
- CNT_W, 8, width of phase timer / time_left (all *_T < 2^CNT_W).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- slow_clk  in  1  divider output (toggling slow clock), asynchronous to control logic
- start  in  1  level request to begin a cycle
- lid_open  in  1  lid sensor, 1 = open
- water_full  in  1  level sensor, 1 = drum full
- pause  in  1  level; freezes active phase
- cancel  in  1  level; abort request
- state  out  3  current state code
- time_left  out  CNT_W  ticks remaining in current phase
- door_lock  out  1  lid lock solenoid
- water_valve  out  1  inlet valve
- drain_valve  out  1  drain pump
- motor_on  out  1  drum motor enable
- motor_fast  out  1  spin speed select
- done  out  1  cycle complete
- fault  out  1  fill timeout

Behaviour:
- Reset (`rst` = 1, asynchronous, active-high; clock `clk`):
  - state = IDLE; time_left = 0; all outputs = 0.
  - Synchroniser flops and edge-detect flop = 0.
  - Reset mid-cycle drops all valves, motor and lock immediately.
- Tick generation:
  - `slow_clk` passes through a 2-flop synchroniser (s1, s2), then a previous-value flop p.
  - tick = s2 & ~p, registered.
  - tick is exactly one `clk` wide, one per `slow_clk` rising edge.
  - tick asserts 3 `clk` edges after the first edge that samples `slow_clk` high.
  - Falling edges produce no tick.
- State codes: IDLE 0, FILL 1, WASH 2, RINSE 3, SPIN 4, DONE 5, FAULT 6.
- Outputs are registered and decoded from the next state, so they change in the same cycle as `state`:
  - FILL: door_lock, water_valve.
  - WASH: door_lock, motor_on.
  - RINSE: door_lock, drain_valve, motor_on.
  - SPIN: door_lock, drain_valve, motor_on, motor_fast.
  - DONE: done.
  - FAULT: fault, drain_valve.
  - IDLE: all 0.
- Timer:
  - On entry to a phase, time_left is loaded with that phase's *_T.
  - A parameter value of 0 is treated as 1.
  - On a tick with pause = 0: if time_left > 1, decrement; if time_left == 1, the phase expires and the next phase loads.
  - A phase therefore lasts exactly N ticks.
  - time_left = 0 in IDLE, DONE and FAULT.
- Transitions, priority per cycle is cancel > pause > sensor/tick:
  - IDLE → FILL when start = 1 and lid_open = 0. start with lid_open = 1 is ignored.
  - FILL → WASH on water_full = 1, sampled every `clk` (not gated by tick).
  - FILL → FAULT on FILL timer expiry. If water_full and expiry occur in the same cycle, WASH wins.
  - WASH → RINSE, RINSE → SPIN, SPIN → DONE on timer expiry.
  - DONE → IDLE when start = 0. done stays high until then, which prevents auto-restart while start is held.
  - FAULT → IDLE only when cancel = 1 (or on rst).
- Cancel:
  - In FILL, WASH or RINSE: go to SPIN with time_left = SPIN_T, so the drum drains before unlock.
  - In SPIN: ignored; the phase runs to completion.
  - In IDLE or DONE: ignored.
- Pause:
  - In FILL through SPIN: state holds and the timer freezes (ticks are discarded).
  - water_valve, drain_valve, motor_on and motor_fast are forced to 0; door_lock stays 1.
  - FILL does not advance on water_full while paused.
  - Release resumes with the same time_left.
- Other inputs:
  - lid_open is ignored outside IDLE (the door is locked).
  - Inputs other than `slow_clk` are assumed synchronous to `clk`.

Test Plan:
- Nominal cycle: FILL_T = 8, WASH_T = 5, RINSE_T = 4, SPIN_T = 3. `slow_clk` period = 20 `clk` cycles; start = 1; water_full raised after 2 ticks. → States run 1, 2, 3, 4, 5, with WASH, RINSE and SPIN lasting exactly 5, 4 and 3 ticks. done = 1, door_lock = 0 in DONE. Drop start → state 0.
- Tick generation: single `slow_clk` rise. → Exactly one 1-`clk` tick, 3 edges after the first high sample; no tick on the fall.
- Lid interlock and fill timeout:
  - start = 1 with lid_open = 1 → state stays 0, outputs 0.
  - With the lid closed and water_full never asserted → after 8 ticks state = 6, fault = 1, drain_valve = 1. cancel → state 0.
- Pause in WASH at time_left = 3: pause held across 4 ticks. → state = 2, time_left = 3, motor_on = 0, door_lock = 1. Release → 3 further ticks, then RINSE.
- Cancel: assert cancel in WASH with time_left = 4. → Next cycle state = 4, time_left = 3. Cancel during SPIN has no effect; the cycle ends in DONE.
- Async reset in RINSE between `clk` edges → state = 0 and all outputs = 0 immediately. After release, the first tick has no effect until start.

Source files
------------

// File: rtl/wash_cycle_controller.sv
// Washing-machine sequencer: turns divider slow_clk edges into one-second ticks
// and steps FILL -> WASH -> RINSE -> SPIN -> DONE, with pause, cancel and
// fill-timeout fault handling. All outputs are registered.
module wash_cycle_controller #(
    parameter int FILL_T  = 8,
    parameter int WASH_T  = 5,
    parameter int RINSE_T = 4,
    parameter int SPIN_T  = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             lid_open,
    input  logic             water_full,
    input  logic             pause,
    input  logic             cancel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] time_left,
    output logic             door_lock,
    output logic             water_valve,
    output logic             drain_valve,
    output logic             motor_on,
    output logic             motor_fast,
    output logic             done,
    output logic             fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    typedef struct packed {
        logic door_lock;
        logic water_valve;
        logic drain_valve;
        logic motor_on;
        logic motor_fast;
        logic done;
        logic fault;
    } ctl_t;

    // A zero duration would never expire, so it is stretched to one tick.
    function automatic logic [CNT_W-1:0] load_val(input int t);
        return (t == 0) ? CNT_W'(1) : CNT_W'(t);
    endfunction

    localparam logic [CNT_W-1:0] FILL_L  = load_val(FILL_T);
    localparam logic [CNT_W-1:0] WASH_L  = load_val(WASH_T);
    localparam logic [CNT_W-1:0] RINSE_L = load_val(RINSE_T);
    localparam logic [CNT_W-1:0] SPIN_L  = load_val(SPIN_T);

    logic             s1, s2, p, tick;
    state_t           st_q, st_d;
    logic [CNT_W-1:0] tl_q, tl_d;
    ctl_t             ctl_q, ctl_d;
    logic             act_d;

    // Synchronise slow_clk and emit a registered one-cycle pulse per rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            p    <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= slow_clk;
            s2   <= s1;
            p    <= s2;
            tick <= s2 & ~p;
        end
    end

    // Next state and phase timer; cancel beats pause beats sensors/ticks.
    always_comb begin
        st_d = st_q;
        tl_d = tl_q;
        unique case (st_q)
            S_IDLE: begin
                tl_d = '0;
                if (start && !lid_open) begin
                    st_d = S_FILL;
                    tl_d = FILL_L;
                end
            end
            S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                if (cancel && st_q != S_SPIN) begin
                    // Always drain through SPIN so the door never unlocks on a full drum.
                    st_d = S_SPIN;
                    tl_d = SPIN_L;
                end else if (!pause) begin
                    if (st_q == S_FILL && water_full) begin
                        st_d = S_WASH;
                        tl_d = WASH_L;
                    end else if (tick) begin
                        if (tl_q > CNT_W'(1)) begin
                            tl_d = tl_q - CNT_W'(1);
                        end else begin
                            unique case (st_q)
                                S_FILL:  begin st_d = S_FAULT; tl_d = '0;      end
                                S_WASH:  begin st_d = S_RINSE; tl_d = RINSE_L; end
                                S_RINSE: begin st_d = S_SPIN;  tl_d = SPIN_L;  end
                                default: begin st_d = S_DONE;  tl_d = '0;      end
                            endcase
                        end
                    end
                end
            end
            S_DONE: begin
                tl_d = '0;
                if (!start) st_d = S_IDLE;
            end
            S_FAULT: begin
                tl_d = '0;
                if (cancel) st_d = S_IDLE;
            end
            default: begin
                st_d = S_IDLE;
                tl_d = '0;
            end
        endcase
    end

    // Decode actuator outputs from the next state so they move with state.
    always_comb begin
        ctl_d = '0;
        act_d = (st_d == S_FILL) || (st_d == S_WASH) || (st_d == S_RINSE) || (st_d == S_SPIN);
        unique case (st_d)
            S_FILL:  begin ctl_d.door_lock = 1'b1; ctl_d.water_valve = 1'b1; end
            S_WASH:  begin ctl_d.door_lock = 1'b1; ctl_d.motor_on = 1'b1; end
            S_RINSE: begin
                ctl_d.door_lock   = 1'b1;
                ctl_d.drain_valve = 1'b1;
                ctl_d.motor_on    = 1'b1;
            end
            S_SPIN:  begin
                ctl_d.door_lock   = 1'b1;
                ctl_d.drain_valve = 1'b1;
                ctl_d.motor_on    = 1'b1;
                ctl_d.motor_fast  = 1'b1;
            end
            S_DONE:  ctl_d.done = 1'b1;
            S_FAULT: begin ctl_d.fault = 1'b1; ctl_d.drain_valve = 1'b1; end
            default: ctl_d = '0;
        endcase
        // Pause stops water and motion but keeps the door locked.
        if (pause && act_d) begin
            ctl_d.water_valve = 1'b0;
            ctl_d.drain_valve = 1'b0;
            ctl_d.motor_on    = 1'b0;
            ctl_d.motor_fast  = 1'b0;
        end
    end

    // State, timer and output registers; reset drops every actuator at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= S_IDLE;
            tl_q  <= '0;
            ctl_q <= '0;
        end else begin
            st_q  <= st_d;
            tl_q  <= tl_d;
            ctl_q <= ctl_d;
        end
    end

    assign state       = st_q;
    assign time_left   = tl_q;
    assign door_lock   = ctl_q.door_lock;
    assign water_valve = ctl_q.water_valve;
    assign drain_valve = ctl_q.drain_valve;
    assign motor_on    = ctl_q.motor_on;
    assign motor_fast  = ctl_q.motor_fast;
    assign done        = ctl_q.done;
    assign fault       = ctl_q.fault;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Bench for wash_cycle_controller: directed scenarios plus random stimulus,
// every cycle compared against a table-driven reference model.
module tb_wash_cycle_controller;

    localparam int FILL_T = 8, WASH_T = 5, RINSE_T = 4, SPIN_T = 3, CNT_W = 8;

    logic clk = 1'b0;
    logic rst, slow_clk, start, lid_open, water_full, pause, cancel;
    logic [2:0] state;
    logic [CNT_W-1:0] time_left;
    logic door_lock, water_valve, drain_valve, motor_on, motor_fast, done, fault;
    logic [6:0] dut_out;

    always #5 clk = ~clk;

    wash_cycle_controller #(.FILL_T(FILL_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T),
                            .SPIN_T(SPIN_T), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .slow_clk(slow_clk), .start(start), .lid_open(lid_open),
        .water_full(water_full), .pause(pause), .cancel(cancel), .state(state),
        .time_left(time_left), .door_lock(door_lock), .water_valve(water_valve),
        .drain_valve(drain_valve), .motor_on(motor_on), .motor_fast(motor_fast),
        .done(done), .fault(fault)
    );

    assign dut_out = {door_lock, water_valve, drain_valve, motor_on, motor_fast, done, fault};

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: phase durations and output patterns as lookup tables.
    // Output bits: {door_lock, water_valve, drain_valve, motor_on, motor_fast, done, fault}
    int dur[7] = '{0, FILL_T, WASH_T, RINSE_T, SPIN_T, 0, 0};
    logic [6:0] otab[7] = '{7'b0000000, 7'b1100000, 7'b1001000, 7'b1011000,
                            7'b1011100, 7'b0000010, 7'b0010001};
    int m_st, m_tl, tick_cnt;
    logic [6:0] m_out;
    logic [3:0] h;  // slow_clk samples at past edges, h[0] newest

    function automatic int ld(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic m_reset();
        m_st = 0; m_tl = 0; m_out = '0; h = '0;
    endtask

    task automatic m_step();
        bit tk, act;
        int ns, nt;
        // A rising edge first sampled at edge n is consumed by the sequencer at edge n+3.
        tk = h[2] & ~h[3];
        if (tk) tick_cnt++;
        ns = m_st; nt = m_tl;
        act = (m_st >= 1 && m_st <= 4);
        if (m_st == 0) begin
            if (start && !lid_open) begin ns = 1; nt = ld(dur[1]); end
        end else if (act) begin
            if (cancel && m_st != 4) begin
                ns = 4; nt = ld(dur[4]);
            end else if (!pause) begin
                if (m_st == 1 && water_full) begin
                    ns = 2; nt = ld(dur[2]);
                end else if (tk) begin
                    if (m_tl > 1) nt = m_tl - 1;
                    else begin
                        ns = (m_st == 1) ? 6 : m_st + 1;
                        nt = (ns <= 4) ? ld(dur[ns]) : 0;
                    end
                end
            end
        end else if (m_st == 5) begin
            if (!start) ns = 0;
        end else if (cancel) ns = 0;
        m_out = otab[ns];
        if (pause && ns >= 1 && ns <= 4) m_out &= 7'b1000011;
        m_st = ns; m_tl = nt;
        h = {h[2:0], slow_clk};
    endtask

    int half_p = 0, sc_cnt = 0;
    bit rnd = 0;
    int prev_st = 0, ent_tick = 0;
    int last_dur[8];

    // One clock: compare at negedge, drive slow_clk/random inputs, advance model at posedge.
    task automatic step();
        @(negedge clk);
        chk("state", state, m_st);
        chk("time_left", time_left, m_tl);
        chk("outputs", dut_out, m_out);
        if (int'(state) != prev_st) begin
            last_dur[prev_st] = tick_cnt - ent_tick;
            ent_tick = tick_cnt;
            prev_st = state;
        end
        if (half_p > 0) begin
            sc_cnt++;
            if (sc_cnt >= half_p) begin sc_cnt = 0; slow_clk = ~slow_clk; end
        end
        if (rnd) begin
            if ($urandom_range(0, 99) < 3) start = ~start;
            if ($urandom_range(0, 99) < 5) lid_open = ~lid_open;
            if ($urandom_range(0, 99) < 4) water_full = ~water_full;
            if ($urandom_range(0, 99) < 3) pause = ~pause;
            cancel = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 199) == 0) half_p = $urandom_range(2, 12);
        end
        @(posedge clk);
        if (rst) m_reset(); else m_step();
        #1;
    endtask

    task automatic wait_for(input int s, input int tl, input int budget, input string tag);
        int k = 0;
        while (!(int'(state) == s && (tl < 0 || int'(time_left) == tl)) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) chk(tag, state, s);
    endtask

    task automatic wait_ticks(input int n, input int budget, input string tag);
        int t0 = tick_cnt;
        int k = 0;
        while (tick_cnt < t0 + n && k < budget) begin step(); k++; end
        if (k >= budget) chk(tag, tick_cnt - t0, n);
    endtask

    int t0;

    initial begin
        rst = 1'b1; slow_clk = 1'b0; start = 1'b0; lid_open = 1'b0;
        water_full = 1'b0; pause = 1'b0; cancel = 1'b0;
        tick_cnt = 0;
        foreach (last_dur[i]) last_dur[i] = 0;
        m_reset();
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_time_left", time_left, 0);
        chk("rst_outputs", dut_out, 0);
        rst = 1'b0;

        // Lid interlock: start with lid open is ignored.
        lid_open = 1'b1; start = 1'b1; half_p = 4;
        repeat (30) step();
        chk("lid_state", state, 0);
        chk("lid_outputs", dut_out, 0);

        // Tick generation: single slow_clk rise while in FILL.
        half_p = 0; slow_clk = 1'b0;
        repeat (8) step();
        lid_open = 1'b0;
        step();
        chk("fill_entry", state, 1);
        chk("fill_load", time_left, FILL_T);
        slow_clk = 1'b1;
        repeat (3) step();
        chk("tick_latency", time_left, FILL_T);
        step();
        chk("tick_one", time_left, FILL_T - 1);
        repeat (10) step();
        chk("tick_single", time_left, FILL_T - 1);
        slow_clk = 1'b0;
        repeat (10) step();
        chk("tick_no_fall", time_left, FILL_T - 1);

        // Fill timeout, then cancel clears the fault.
        start = 1'b0; half_p = 10;
        wait_for(6, -1, FILL_T * 20 + 100, "fill_timeout");
        chk("fault_flag", fault, 1);
        chk("fault_drain", drain_valve, 1);
        chk("fault_time_left", time_left, 0);
        cancel = 1'b1;
        step();
        chk("fault_cancel", state, 0);
        cancel = 1'b0;

        // Nominal cycle with 20-clock slow period.
        start = 1'b1;
        wait_for(1, -1, 20, "nom_fill");
        wait_ticks(2, 100, "nom_ticks");
        water_full = 1'b1;
        wait_for(2, -1, 10, "nom_wash");
        water_full = 1'b0;
        wait_for(5, -1, 400, "nom_done");
        step();
        chk("wash_ticks", last_dur[2], WASH_T);
        chk("rinse_ticks", last_dur[3], RINSE_T);
        chk("spin_ticks", last_dur[4], SPIN_T);
        chk("done_flag", done, 1);
        chk("done_unlock", door_lock, 0);
        start = 1'b0;
        step();
        chk("nom_idle", state, 0);

        // Pause in WASH at time_left 3 across four ticks.
        start = 1'b1; water_full = 1'b1;
        wait_for(2, -1, 20, "p_wash");
        water_full = 1'b0;
        wait_for(2, 3, 200, "p_tl3");
        pause = 1'b1;
        wait_ticks(4, 200, "p_ticks");
        step();
        chk("pause_state", state, 2);
        chk("pause_time_left", time_left, 3);
        chk("pause_motor", motor_on, 0);
        chk("pause_lock", door_lock, 1);
        pause = 1'b0;
        t0 = tick_cnt;
        wait_for(3, -1, 200, "p_rinse");
        chk("pause_resume_ticks", tick_cnt - t0, 3);
        wait_for(5, -1, 400, "p_done");
        start = 1'b0;
        step();

        // Cancel in WASH at time_left 4; cancel held through SPIN is ignored.
        start = 1'b1; water_full = 1'b1;
        wait_for(2, -1, 20, "c_wash");
        water_full = 1'b0;
        wait_for(2, 4, 200, "c_tl4");
        cancel = 1'b1;
        step();
        chk("cancel_spin", state, 4);
        chk("cancel_time_left", time_left, SPIN_T);
        wait_for(5, -1, 200, "cancel_done");
        chk("cancel_done_flag", done, 1);
        cancel = 1'b0; start = 1'b0;
        step();
        chk("cancel_idle", state, 0);

        // Asynchronous reset between clock edges during RINSE.
        start = 1'b1; water_full = 1'b1;
        wait_for(2, -1, 20, "r_wash");
        water_full = 1'b0;
        wait_for(3, -1, 300, "r_rinse");
        #1 rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_time_left", time_left, 0);
        chk("arst_outputs", dut_out, 0);
        m_reset();
        repeat (2) step();
        rst = 1'b0; start = 1'b0;
        repeat (60) step();
        chk("arst_idle_hold", state, 0);
        start = 1'b1;
        step();
        chk("arst_restart", state, 1);

        // Random stimulus against the model.
        half_p = 5; rnd = 1'b1;
        repeat (3000) step();
        rnd = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
